// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Load/store port between the CPU datapath (master) and the multi-cycle
//   data-memory responder (slave).
//
//   Signals (directions as seen from the responder):
//     req_i   in   request strobe, sampled only while the responder is idle
//     we_i    in   1 = store, 0 = load
//     addr_i  in   byte address
//     data_i  in   store data
//     data_o  out  load data, valid only while ready_o = 1
//     ready_o out  one-cycle completion pulse
//     busy_o  out  transaction outstanding
//     err_o   out  misaligned-access flag (only with DMEM_ALIGN_CHECK_EN)
//
//   Optional feature macro: DMEM_ALIGN_CHECK_EN
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        busy_o;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, data_i,
        input  data_o, ready_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output data_o, ready_o, busy_o, err_o
    );
`else
    modport master (
        output req_i, we_i, addr_i, data_i,
        input  data_o, ready_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output data_o, ready_o, busy_o
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle word-addressed data memory for a stall-capable CPU.
//   One load or store is accepted while idle; the access completes LATENCY
//   cycles after the accept edge with a single-cycle ready_o pulse.
//
//   Parameters:
//     DEPTH    number of 32-bit words (power of two, 4..4096)
//     LATENCY  accept-to-ready cycles (1..15)
//
//   Ports:
//     clk_i    clock, rising edge
//     rst_i    asynchronous active-high reset (clears FSM, outputs, array)
//     dmem     dmem_responder_if.slave: req/we/addr/data in,
//              data_o/ready_o/busy_o (and err_o) out, all registered
//
//   Optional feature macro: DMEM_ALIGN_CHECK_EN
//     When defined, a latched address with addr[1:0] != 0 completes with
//     err_o = 1, data_o = 0 and no array write. When undefined, addr[1:0]
//     is ignored and err_o does not exist.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   dmem
);

    localparam int AW = $clog2(DEPTH);
    // Counter preload; a LATENCY of 1 never visits WAIT so the value is moot.
    localparam logic [3:0] LAT_M2 = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;

    logic            r_we;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_data;
    logic [31:0]     r_mem [DEPTH];

    logic            r_ready;
    logic            r_busy;
    logic [31:0]     r_data_o;

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_tx_we;
    logic [AW-1:0]   w_tx_idx;
    logic [31:0]     w_tx_data;
    logic            w_tx_mis;

    // Address bits above the word index alias and are intentionally dropped.
`ifdef DMEM_ALIGN_CHECK_EN
    logic            r_mis;
    logic            r_err;
    wire             w_unused_addr = ^{1'b0, dmem.addr_i[31:AW+2]};
`else
    wire             w_unused_addr = ^{1'b0, dmem.addr_i[31:AW+2], dmem.addr_i[1:0]};
`endif

    assign w_accept     = (r_state == ST_IDLE) && dmem.req_i;
    assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

    // With LATENCY = 1 the RESP edge is also the accept edge, so the access
    // has to use the live inputs instead of the not-yet-latched copies.
    assign w_tx_we   = (r_state == ST_IDLE) ? dmem.we_i             : r_we;
    assign w_tx_idx  = (r_state == ST_IDLE) ? dmem.addr_i[AW+1:2]   : r_idx;
    assign w_tx_data = (r_state == ST_IDLE) ? dmem.data_i           : r_data;
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_tx_mis  = (r_state == ST_IDLE) ? (dmem.addr_i[1:0] != 2'b00) : r_mis;
`else
    assign w_tx_mis  = 1'b0;
`endif

    // Next-state and countdown logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (dmem.req_i) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LAT_M2;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request capture on acceptance; inputs are don't-care afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we   <= 1'b0;
            r_idx  <= '0;
            r_data <= 32'd0;
        end else if (w_accept) begin
            r_we   <= dmem.we_i;
            r_idx  <= dmem.addr_i[AW+1:2];
            r_data <= dmem.data_i;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Misalignment capture and registered error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mis <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mis <= (dmem.addr_i[1:0] != 2'b00);
            end
            r_err <= w_enter_resp && w_tx_mis;
        end
    end

    assign dmem.err_o = r_err;
`endif

    // Storage array: a store commits on the edge that enters RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_enter_resp && w_tx_we && !w_tx_mis) begin
            r_mem[w_tx_idx] <= w_tx_data;
        end
    end

    // Registered outputs; data_o is held at zero outside a load response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_data_o <= 32'd0;
        end else begin
            r_ready  <= w_enter_resp;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_data_o <= (w_enter_resp && !w_tx_we && !w_tx_mis) ? r_mem[w_tx_idx] : 32'd0;
        end
    end

    assign dmem.ready_o = r_ready;
    assign dmem.busy_o  = r_busy;
    assign dmem.data_o  = r_data_o;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Five responders with LATENCY 2, 1, 3, 15 and 4 (DEPTH 128) share one
//   stimulus stream. Each has a behavioural model (age-of-transaction plus
//   an array); one compare process checks every output on every negedge,
//   together with literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NI  = 5;
    localparam int DEP = 128;
    localparam int LATS [NI] = '{2, 1, 3, 15, 4};

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        req  = 1'b0;
    logic        we   = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din  = 32'd0;

    always #5 clk = ~clk;

    logic [NI-1:0] rdy_v, busy_v;
    logic [31:0]   dout_v [NI];
    logic [NI-1:0] e_rdy_v, e_bsy_v;
    logic [31:0]   e_d_v  [NI];
`ifdef DMEM_ALIGN_CHECK_EN
    logic [NI-1:0] err_v, e_err_v;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Directed-expectation controls, written by the stimulus process.
    int          dir_c      = 0;
    string       dir_nm     = "";
    logic [31:0] dir_d      = 32'd0;
    bit          dir_e      = 1'b0;
    bit          dir_rstchk = 1'b0;

    generate
        for (genvar k = 0; k < NI; k++) begin : g_lat
            dmem_responder_if u_if ();

            dmem_responder #(.DEPTH(DEP), .LATENCY(LATS[k])) u_dut (
                .clk_i (clk),
                .rst_i (rst),
                .dmem  (u_if.slave)
            );

            assign u_if.req_i  = req;
            assign u_if.we_i   = we;
            assign u_if.addr_i = addr;
            assign u_if.data_i = din;
            assign rdy_v[k]    = u_if.ready_o;
            assign busy_v[k]   = u_if.busy_o;
            assign dout_v[k]   = u_if.data_o;

            // Model: a transaction is "age" edges old; it responds at age LATENCY.
            bit          pend = 1'b0;
            int          age  = 0;
            bit          m_we = 1'b0;
            bit          m_mis = 1'b0;
            int          m_idx = 0;
            logic [31:0] m_d  = 32'd0;
            logic [31:0] mem [DEP];
            bit          e_rdy = 1'b0;
            bit          e_bsy = 1'b0;
            bit          e_err = 1'b0;
            logic [31:0] e_d  = 32'd0;

            assign e_rdy_v[k] = e_rdy;
            assign e_bsy_v[k] = e_bsy;
            assign e_d_v[k]   = e_d;
`ifdef DMEM_ALIGN_CHECK_EN
            assign err_v[k]   = u_if.err_o;
            assign e_err_v[k] = e_err;
`endif

            initial begin
                for (int i = 0; i < DEP; i++) mem[i] = 32'd0;
                forever begin
                    @(posedge clk or posedge rst);
                    if (rst) begin
                        pend = 1'b0; age = 0;
                        e_rdy = 1'b0; e_bsy = 1'b0; e_err = 1'b0; e_d = 32'd0;
                        for (int i = 0; i < DEP; i++) mem[i] = 32'd0;
                    end else begin
                        if (!pend) begin
                            if (req) begin
                                pend  = 1'b1;
                                age   = 1;
                                m_we  = we;
                                m_idx = int'(addr >> 2) % DEP;
                                m_d   = din;
`ifdef DMEM_ALIGN_CHECK_EN
                                m_mis = (addr % 4) != 0;
`else
                                m_mis = 1'b0;
`endif
                            end
                        end else begin
                            age = age + 1;
                            if (age > LATS[k]) pend = 1'b0;
                        end
                        e_rdy = pend && (age == LATS[k]);
                        e_bsy = pend;
                        e_err = 1'b0;
                        e_d   = 32'd0;
                        if (e_rdy) begin
                            if (m_mis)     e_err = 1'b1;
                            else if (m_we) mem[m_idx] = m_d;
                            else           e_d = mem[m_idx];
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: dut=%08h expected=%08h", nm, act, exp);
        end
    endtask

    // Single compare process: model checks every cycle, literal checks when armed.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("model ready L%0d", LATS[k]), 32'(rdy_v[k]), 32'(e_rdy_v[k]));
                chk($sformatf("model busy L%0d", LATS[k]), 32'(busy_v[k]), 32'(e_bsy_v[k]));
                if (e_rdy_v[k]) chk($sformatf("model data L%0d", LATS[k]), dout_v[k], e_d_v[k]);
`ifdef DMEM_ALIGN_CHECK_EN
                chk($sformatf("model err L%0d", LATS[k]), 32'(err_v[k]), 32'(e_err_v[k]));
`endif
                if (dir_rstchk) begin
                    chk($sformatf("reset ready L%0d", LATS[k]), 32'(rdy_v[k]), 32'd0);
                    chk($sformatf("reset busy L%0d", LATS[k]), 32'(busy_v[k]), 32'd0);
                    chk($sformatf("reset data L%0d", LATS[k]), dout_v[k], 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
                    chk($sformatf("reset err L%0d", LATS[k]), 32'(err_v[k]), 32'd0);
`endif
                end
                if (dir_c > 0) begin
                    chk($sformatf("%s ready L%0d c%0d", dir_nm, LATS[k], dir_c),
                        32'(rdy_v[k]), 32'(dir_c == LATS[k]));
                    chk($sformatf("%s busy L%0d c%0d", dir_nm, LATS[k], dir_c),
                        32'(busy_v[k]), 32'(dir_c <= LATS[k]));
                    if (dir_c == LATS[k]) begin
                        chk($sformatf("%s data L%0d", dir_nm, LATS[k]), dout_v[k],
                            dir_e ? 32'd0 : dir_d);
`ifdef DMEM_ALIGN_CHECK_EN
                        chk($sformatf("%s err L%0d", dir_nm, LATS[k]), 32'(err_v[k]), 32'(dir_e));
`endif
                    end
                end
            end
        end
    end

    // Arms literal checks for cycles 1..17 after an accept edge.
    task automatic observe(input string nm, input logic [31:0] ed, input bit ee, input bit poke);
        dir_nm = nm;
        dir_d  = ed;
        dir_e  = ee;
        for (int c = 1; c <= 17; c++) begin
            dir_c = c;
            if (poke && c == 1) begin
                req = 1'b1; we = 1'b1; addr = 32'h20; din = 32'h1;
            end else begin
                req = 1'b0;
            end
            @(posedge clk); #2;
        end
        dir_c = 0;
    endtask

    task automatic txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input bit ee, input bit poke);
        req = 1'b1; we = w; addr = a; din = d;
        @(posedge clk); #2;
        req = 1'b0;
        observe(nm, ed, ee, poke);
    endtask

    initial begin
        logic [31:0] r;
        int tot_vec;
        int tot_miss;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 dir_rstchk = 1'b1;
        @(posedge clk); #2;
        dir_rstchk = 1'b0;
        rst = 1'b0;
        @(posedge clk); #2;

        txn("wr_dead", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        txn("rd_dead", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        txn("rd_poke", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
        txn("rd_20",   1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
        txn("wr_alias", 1'b1, 32'h204, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        txn("rd_alias", 1'b0, 32'h004, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

        // Store then reset in cycle 2; a load is held pending across deassertion.
        req = 1'b1; we = 1'b1; addr = 32'h8; din = 32'h55;
        @(posedge clk); #2;
        req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        dir_rstchk = 1'b1;
        we = 1'b0; addr = 32'h8; req = 1'b1;
        @(posedge clk); #2;
        dir_rstchk = 1'b0;
        rst = 1'b0;
        @(posedge clk); #2;
        req = 1'b0;
        observe("rd_after_rst", 32'h0, 1'b0, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        txn("wr_mis", 1'b1, 32'h12, 32'h77, 32'h0, 1'b1, 1'b0);
        txn("rd_10",  1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
`else
        txn("wr_mis", 1'b1, 32'h12, 32'h77, 32'h0, 1'b0, 1'b0);
        txn("rd_10",  1'b0, 32'h10, 32'h0, 32'h77, 1'b0, 1'b0);
`endif

        // Random traffic with occasional reset pulses; the models check it.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            req = ($urandom_range(0, 2) == 0);
            we  = 1'($urandom_range(0, 1));
            r   = $urandom;
            addr = (r & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
                 | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            din = $urandom;
            @(posedge clk); #2;
        end
        rst = 1'b0;
        req = 1'b0;
        repeat (20) @(posedge clk);
        #2;

        tot_vec  = n_vec;
        tot_miss = n_miss;
        $display("== %0d vectors applied, %0d miscompares ==", tot_vec, tot_miss);
        $finish;
    end

endmodule
